// File: rtl/fifo_pkg.sv
// Shared types and constants for the native-FIFO read adapter and its holding buffer.
package fifo_pkg;

   localparam int SKID_DEPTH = 2;

   typedef logic [1:0] occ_t;

   typedef enum logic [1:0] {
      BUF_EMPTY,
      BUF_ONE,
      BUF_TWO
   } buf_state_t;

   function automatic buf_state_t occ_to_state(input occ_t occ);
      case (occ)
         2'd0:    return BUF_EMPTY;
         2'd1:    return BUF_ONE;
         default: return BUF_TWO;
      endcase
   endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry holding buffer that absorbs the FIFO's registered read latency.
// Push writes at the tail, pop advances the head; both pointers wrap modulo 2.
module fifo_rd_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output occ_t                  occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic head_q, head_d;
   logic tail_q, tail_d;
   occ_t occ_q, occ_d;
   logic [DATA_WIDTH-1:0] entries [SKID_DEPTH];

   always_comb begin
      head_d = pop  ? ~head_q : head_q;
      tail_d = push ? ~tail_q : tail_q;
      occ_d  = occ_q + occ_t'(push) - occ_t'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q <= 1'b0;
         tail_q <= 1'b0;
         occ_q  <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
      end
   end

   for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_q, entry_d;

      always_comb begin
         entry_d = (push && (tail_q == 1'(gi))) ? push_data : entry_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            entry_q <= '0;
         end else begin
            entry_q <= entry_d;
         end
      end

      assign entries[gi] = entry_q;
   end

   assign occ       = occ_q;
   assign head_data = entries[head_q];

endmodule

// File: rtl/sync_fifo_native_rd_adapter.sv
// Turns the native FIFO read port (1-cycle registered read) into a valid/ready stream.
// Optional m_last packet marking is enabled with the FIFO_RD_LAST_EN macro.
module sync_fifo_native_rd_adapter
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int PKT_LEN    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_LAST_EN
   ,
   output logic                  m_last
`endif
);

   logic                  infl_q, infl_d;
   occ_t                  occ;
   logic [DATA_WIDTH-1:0] head_data;
   buf_state_t            buf_state;
   logic                  pop;
   logic [2:0]            demand;

   // A read is only issued if the beat it returns is guaranteed a free slot.
   always_comb begin
      buf_state  = occ_to_state(occ);
      m_valid    = !rst && (buf_state != BUF_EMPTY);
      m_data     = rst ? '0 : head_data;
      pop        = m_valid && m_ready;
      demand     = 3'(occ) + 3'(infl_q) - 3'(pop);
      fifo_rd_en = !fifo_empty && !rst && (demand <= 3'd1);
      infl_d     = fifo_rd_en;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         infl_q <= 1'b0;
      end else begin
         infl_q <= infl_d;
      end
   end

   fifo_rd_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (infl_q),
      .push_data (fifo_rd_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (head_data)
   );

`ifdef FIFO_RD_LAST_EN
   localparam int CNT_W = $clog2(PKT_LEN);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         cnt_d = (cnt_q == CNT_W'(PKT_LEN - 1)) ? '0 : cnt_q + CNT_W'(1);
      end
      m_last = m_valid && (cnt_q == CNT_W'(PKT_LEN - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

endmodule
